// File: rtl/adder_response_checker.sv
// Response checker for an unsigned WIDTH-bit adder: compares each sampled
// {cout,out} against in0+in1, counts errors, captures the first failure and tracks pair coverage.
module adder_response_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   out,
    input  logic               cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [2*WIDTH:0]   cov_count,
    output logic               ff_valid,
    output logic [WIDTH-1:0]   ff_in0,
    output logic [WIDTH-1:0]   ff_in1,
    output logic [WIDTH:0]     ff_sum
);

    localparam int                PAIRS    = 1 << (2 * WIDTH);
    localparam logic [2*WIDTH:0]  COV_FULL = (2 * WIDTH + 1)'(PAIRS);
    localparam logic [2*WIDTH:0]  COV_ONE  = (2 * WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0]  ERR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ERR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [PAIRS-1:0]     seen;
    logic [WIDTH:0]       exp_sum;
    logic [WIDTH:0]       got_sum;
    logic                 mismatch;
    logic [2*WIDTH-1:0]   idx;
    logic [CNT_W-1:0]     err_next;
    logic [2*WIDTH:0]     cov_next;

    // Golden sum is kept one bit wider so the carry is checked, not truncated.
    assign exp_sum  = {1'b0, in0} + {1'b0, in1};
    assign got_sum  = {cout, out};
    assign mismatch = (got_sum != exp_sum);
    assign idx      = {in0, in1};
    assign err_next = (mismatch && (err_count != ERR_MAX)) ? err_count + ERR_ONE : err_count;
    assign cov_next = cov_count + COV_ONE;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            // NOTE: the coverage bitmap is reset explicitly; a stale bit would
            // silently under-count coverage, so it cannot be left uninitialised.
            seen      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            cov_count <= '0;
            ff_valid  <= 1'b0;
            ff_in0    <= '0;
            ff_in1    <= '0;
            ff_sum    <= '0;
        end else if (start) begin
            // A sample arriving alongside start is dropped with the old run.
            state     <= RUN;
            seen      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            cov_count <= '0;
            ff_valid  <= 1'b0;
            ff_in0    <= '0;
            ff_in1    <= '0;
            ff_sum    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (in_valid) begin
                        err_count <= err_next;
                        if (mismatch && !ff_valid) begin
                            ff_valid <= 1'b1;
                            ff_in0   <= in0;
                            ff_in1   <= in1;
                            ff_sum   <= got_sum;
                        end
                        if (!seen[idx]) begin
                            seen[idx] <= 1'b1;
                            cov_count <= cov_next;
                            if (cov_next == COV_FULL) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (err_next == '0);
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold everything until start or rst.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_response_checker.sv
// Scoreboard bench for adder_response_checker: a driver pushes model snapshots,
// a monitor pops and compares them against both DUT instances every cycle.
module tb_adder_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in0 = '0;
    logic [3:0] in1 = '0;
    logic [3:0] out = '0;
    logic       cout = 1'b0;

    logic        busy, done, pass, ff_valid;
    logic [15:0] err_count;
    logic [8:0]  cov_count;
    logic [3:0]  ff_in0, ff_in1;
    logic [4:0]  ff_sum;

    logic        d4_busy, d4_done, d4_pass, d4_ffv;
    logic [3:0]  d4_err;
    logic [8:0]  d4_cov;
    logic [3:0]  d4_ffa, d4_ffb;
    logic [4:0]  d4_ffs;

    always #5 clk = ~clk;

    adder_response_checker #(.WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in0(in0), .in1(in1), .out(out), .cout(cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .cov_count(cov_count), .ff_valid(ff_valid), .ff_in0(ff_in0),
        .ff_in1(ff_in1), .ff_sum(ff_sum)
    );

    // Narrow-counter instance shares the stimulus to exercise saturation.
    adder_response_checker #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in0(in0), .in1(in1), .out(out), .cout(cout),
        .busy(d4_busy), .done(d4_done), .pass(d4_pass), .err_count(d4_err),
        .cov_count(d4_cov), .ff_valid(d4_ffv), .ff_in0(d4_ffa),
        .ff_in1(d4_ffb), .ff_sum(d4_ffs)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] err;
        logic [3:0]  err4;
        logic [8:0]  cov;
        logic        ff_valid;
        logic [3:0]  ff_in0;
        logic [3:0]  ff_in1;
        logic [4:0]  ff_sum;
    } snap_t;

    snap_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Reference model state: 0=IDLE 1=RUN 2=DONE
    int         m_state = 0;
    bit [255:0] m_map;
    int         m_err, m_err4, m_cov;
    logic       m_ffv;
    logic [3:0] m_ffa, m_ffb;
    logic [4:0] m_ffs;

    task automatic model_clear();
        m_map  = '0;
        m_err  = 0;
        m_err4 = 0;
        m_cov  = 0;
        m_ffv  = 1'b0;
        m_ffa  = '0;
        m_ffb  = '0;
        m_ffs  = '0;
    endtask

    task automatic model_step(input logic r, input logic st, input logic v,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] o, input logic c);
        logic [4:0] s;
        logic [7:0] k;
        if (r) begin
            m_state = 0;
            model_clear();
        end else if (st) begin
            m_state = 1;
            model_clear();
        end else if (m_state == 1 && v) begin
            s = {1'b0, a} + {1'b0, b};
            if ({c, o} != s) begin
                if (m_err < 65535) m_err++;
                if (m_err4 < 15) m_err4++;
                if (!m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffa = a;
                    m_ffb = b;
                    m_ffs = {c, o};
                end
            end
            k = {a, b};
            if (!m_map[k]) begin
                m_map[k] = 1'b1;
                m_cov++;
                if (m_cov == 256) m_state = 2;
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.busy     = (m_state == 1);
        s.done     = (m_state == 2);
        s.pass     = (m_state == 2) && (m_err == 0);
        s.err      = 16'(m_err);
        s.err4     = 4'(m_err4);
        s.cov      = 9'(m_cov);
        s.ff_valid = m_ffv;
        s.ff_in0   = m_ffa;
        s.ff_in1   = m_ffb;
        s.ff_sum   = m_ffs;
        return s;
    endfunction

    task automatic cycle(input logic r, input logic st, input logic v,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] o, input logic c);
        @(negedge clk);
        rst = r; start = st; in_valid = v;
        in0 = a; in1 = b; out = o; cout = c;
        @(posedge clk);
        model_step(r, st, v, a, b, o, c);
        sb_q.push_back(model_snap());
        #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic sample(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] o, input logic c);
        cycle(1'b0, 1'b0, 1'b1, a, b, o, c);
    endtask

    task automatic do_start();
        cycle(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    // Pairs lo..hi in {in0,in1} order; inject forces out=0 at (3,5).
    task automatic sweep(input int lo, input int hi, input bit inject);
        logic [7:0] p;
        logic [4:0] s;
        for (int i = lo; i <= hi; i++) begin
            p = 8'(i);
            s = {1'b0, p[7:4]} + {1'b0, p[3:0]};
            if (inject && p == 8'h35) s = 5'b00000;
            sample(p[7:4], p[3:0], s[3:0], s[4]);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s: done not seen within 20 cycles (done=%b)", name, done);
        end
    endtask

    // Monitor: each cycle that has a scoreboard entry, compare both instances.
    initial begin
        snap_t e, a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {busy, done, pass, err_count, d4_err, cov_count,
                     ff_valid, ff_in0, ff_in1, ff_sum};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL scoreboard @%0t: got %h expected %h", $time, a, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, and in_valid ignored while IDLE
        do_reset();
        sample(4'h2, 4'h2, 4'h0, 1'b0);
        settle();
        check("reset_busy", 32'(busy), 0);
        check("reset_err", 32'(err_count), 0);
        check("idle_cov", 32'(cov_count), 0);

        // Full correct sweep
        do_start();
        sweep(0, 255, 1'b0);
        wait_done("sweep_done");
        check("sweep_cov", 32'(cov_count), 256);
        check("sweep_pass", 32'(pass), 1);
        check("sweep_ffv", 32'(ff_valid), 0);

        // Sweep with a single bad sum at (3,5); DONE then ignores samples
        do_start();
        sweep(0, 255, 1'b1);
        wait_done("fault_done");
        sample(4'h1, 4'h1, 4'h0, 1'b0);
        settle();
        check("fault_err", 32'(err_count), 1);
        check("fault_pass", 32'(pass), 0);
        check("fault_ff", {19'd0, ff_valid, ff_in0, ff_in1, ff_sum}, {19'd0, 1'b1, 4'd3, 4'd5, 5'b00000});

        // Carry: 15+1 must report cout=1
        do_start();
        sample(4'hf, 4'h1, 4'h0, 1'b0);
        sample(4'hf, 4'h1, 4'h0, 1'b1);
        settle();
        check("carry_err", 32'(err_count), 1);
        check("carry_ffsum", 32'(ff_sum), 0);
        check("carry_cov", 32'(cov_count), 1);

        // Duplicates add no coverage; done only on the final new pair
        do_start();
        for (int i = 0; i < 10; i++) sample(4'h7, 4'h7, 4'he, 1'b0);
        settle();
        check("dup_cov", 32'(cov_count), 1);
        sweep(0, 254, 1'b0);
        settle();
        check("dup_cov255", 32'(cov_count), 255);
        check("dup_not_done", 32'(done), 0);
        sample(4'hf, 4'hf, 4'he, 1'b1);
        wait_done("dup_done");

        // 20 failing samples: wide counter 20, narrow counter pinned at 15
        do_start();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] p;
            logic [4:0] s;
            p = 8'(i);
            s = {1'b0, p[7:4]} + {1'b0, p[3:0]};
            sample(p[7:4], p[3:0], ~s[3:0], s[4]);
        end
        settle();
        check("sat_err16", 32'(err_count), 20);
        check("sat_err4", 32'(d4_err), 15);

        // rst mid-run, then start colliding with a sample
        do_start();
        sweep(0, 99, 1'b0);
        do_reset();
        settle();
        check("midrst_cov", 32'(cov_count), 0);
        check("midrst_busy", 32'(busy), 0);
        do_start();
        sample(4'h1, 4'h2, 4'h0, 1'b0);
        sample(4'h2, 4'h2, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 4'h4, 4'h4, 4'h0, 1'b0);
        settle();
        check("restart_err", 32'(err_count), 0);
        check("restart_cov", 32'(cov_count), 0);
        check("restart_busy", 32'(busy), 1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
